// File: rtl/mac_array_seq_pkg.sv
// mac_array_seq_pkg: shared definitions for the MAC array sequencer.
//   - state_t    : sequencer FSM states
//   - INST_*     : array instruction encodings driven on inst_w
//   - inst_of()  : state -> instruction mapping (before the alignment register)
package mac_array_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GAP   = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // Instruction the array should see for the SRAM data read in a given state.
  function automatic logic [1:0] inst_of(input state_t st);
    logic [1:0] inst;
    case (st)
      ST_LOAD: inst = INST_LOAD;
      ST_EXEC: inst = INST_EXEC;
      default: inst = INST_IDLE;
    endcase
    return inst;
  endfunction

endpackage

// File: rtl/mac_array_seq_if.sv
// mac_array_seq_if: request/SRAM/array-edge signals of the sequencer.
//   master : pass requester (drives start, num_vec, w_base, a_base)
//   slave  : the sequencer (drives busy, done, rd_en, rd_addr, inst_w, ofifo_wr)
interface mac_array_seq_if #(
  parameter int len_bw  = 8,
  parameter int addr_bw = 11
) ();

  logic               start;
  logic [len_bw-1:0]  num_vec;
  logic [addr_bw-1:0] w_base;
  logic [addr_bw-1:0] a_base;
  logic               busy;
  logic               done;
  logic               rd_en;
  logic [addr_bw-1:0] rd_addr;
  logic [1:0]         inst_w;
  logic               ofifo_wr;

  modport master (
    output start, num_vec, w_base, a_base,
    input  busy, done, rd_en, rd_addr, inst_w, ofifo_wr
  );

  modport slave (
    input  start, num_vec, w_base, a_base,
    output busy, done, rd_en, rd_addr, inst_w, ofifo_wr
  );

endinterface

// File: rtl/mac_array_seq_counter.sv
// seq_counter: loadable down-counter with zero flag.
//   clk, reset (async active-low), load/load_val (load has priority),
//   dec (decrement, saturates at zero), count, zero (count == 0).
module seq_counter #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] load_val,
  input  logic             dec,
  output logic [width-1:0] count,
  output logic             zero
);

  logic [width-1:0] count_r;

  // Count register: load, else decrement while non-zero, else hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {width{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {width{1'b0}})) begin
      count_r <= count_r - {{(width-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {width{1'b0}});

endmodule

// File: rtl/mac_array_seq.sv
// mac_array_seq: sequencer for one pass of the systolic MAC array.
//   Loads `row` kernel rows, streams `num_vec` activation vectors and marks
//   the cycles in which finished partial sums reach the capture point.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset (all outputs forced to 0)
//   bus    : mac_array_seq_if.slave
//            in : start, num_vec, w_base, a_base
//            out: busy, done, rd_en, rd_addr, inst_w, ofifo_wr
module mac_array_seq
  import mac_array_seq_pkg::*;
#(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int psum_lat = row + col - 1,
  parameter int len_bw   = 8,
  parameter int addr_bw  = 11
) (
  input  logic          clk,
  input  logic          reset,
  mac_array_seq_if.slave bus
);

  localparam int ROW_W = $clog2(row + 1);
  localparam int PH_W  = (len_bw > ROW_W) ? len_bw : ROW_W;
  localparam int DLY_W = $clog2(psum_lat + 1);

  state_t             state_r;
  logic               busy_r;
  logic               done_r;
  logic               rd_en_r;
  logic [addr_bw-1:0] rd_addr_r;
  logic [1:0]         inst_r;
  logic               ofifo_r;
  logic [len_bw-1:0]  num_vec_r;
  logic [addr_bw-1:0] a_base_r;

  logic               ph_load_s;
  logic [PH_W-1:0]    ph_val_s;
  logic               ph_dec_s;
  logic [PH_W-1:0]    ph_count_s;
  logic               ph_zero_s;
  logic               ph_last_s;

  logic               dly_load_s;
  logic               dly_dec_s;
  logic [DLY_W-1:0]   dly_count_s;
  logic               dly_zero_s;
  logic               fire_s;

  logic               len_load_s;
  logic               len_dec_s;
  logic [len_bw-1:0]  len_count_s;
  logic               len_zero_s;
  logic               cap_last_s;

  // Phase counter: LOAD length, then EXEC length.
  seq_counter #(.width(PH_W)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load_s),
    .load_val (ph_val_s),
    .dec      (ph_dec_s),
    .count    (ph_count_s),
    .zero     (ph_zero_s)
  );

  // Capture delay: psum_lat cycles from the first execute instruction.
  seq_counter #(.width(DLY_W)) u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (dly_load_s),
    .load_val (DLY_W'(psum_lat)),
    .dec      (dly_dec_s),
    .count    (dly_count_s),
    .zero     (dly_zero_s)
  );

  // Capture length: num_vec strobe cycles.
  seq_counter #(.width(len_bw)) u_length (
    .clk      (clk),
    .reset    (reset),
    .load     (len_load_s),
    .load_val (num_vec_r),
    .dec      (len_dec_s),
    .count    (len_count_s),
    .zero     (len_zero_s)
  );

  // A zero count also ends a phase, so a corrupted counter cannot stall the pass.
  assign ph_last_s  = (ph_count_s == PH_W'(1)) || ph_zero_s;
  // Delay reaching 1 means the next cycle is the first capture cycle.
  assign fire_s     = (dly_count_s == DLY_W'(1));
  assign cap_last_s = ofifo_r && ((len_count_s == len_bw'(1)) || len_zero_s);

  // Counter controls derived from the current state.
  always_comb begin
    ph_load_s  = 1'b0;
    ph_val_s   = {PH_W{1'b0}};
    ph_dec_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          ph_load_s = 1'b1;
          ph_val_s  = PH_W'(row);
        end else begin
          ph_load_s = 1'b0;
        end
      end
      ST_LOAD: ph_dec_s = 1'b1;
      ST_GAP: begin
        if (num_vec_r != {len_bw{1'b0}}) begin
          ph_load_s = 1'b1;
          ph_val_s  = PH_W'(num_vec_r);
        end else begin
          ph_load_s = 1'b0;
        end
      end
      ST_EXEC: ph_dec_s = 1'b1;
      default: ph_dec_s = 1'b0;
    endcase
  end

  // The first EXEC state cycle is the one where the execute instruction is
  // registered onto inst_w, so the delay holds psum_lat during that cycle.
  assign dly_load_s = (state_r == ST_EXEC) && (inst_r == INST_IDLE);
  assign dly_dec_s  = !dly_zero_s;
  assign len_load_s = fire_s;
  assign len_dec_s  = ofifo_r;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rd_en_r   <= 1'b0;
      rd_addr_r <= {addr_bw{1'b0}};
      inst_r    <= INST_IDLE;
      ofifo_r   <= 1'b0;
      num_vec_r <= {len_bw{1'b0}};
      a_base_r  <= {addr_bw{1'b0}};
    end else begin
      // One register stage aligns the instruction with SRAM read data.
      inst_r  <= inst_of(state_r);
      ofifo_r <= fire_s || (ofifo_r && !cap_last_s);
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            num_vec_r <= bus.num_vec;
            a_base_r  <= bus.a_base;
            busy_r    <= 1'b1;
            rd_en_r   <= 1'b1;
            rd_addr_r <= bus.w_base;
            state_r   <= ST_LOAD;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (ph_last_s) begin
            rd_en_r   <= 1'b0;
            rd_addr_r <= {addr_bw{1'b0}};
            state_r   <= ST_GAP;
          end else begin
            rd_addr_r <= rd_addr_r + addr_bw'(1);
          end
        end
        ST_GAP: begin
          if (num_vec_r != {len_bw{1'b0}}) begin
            rd_en_r   <= 1'b1;
            rd_addr_r <= a_base_r;
            state_r   <= ST_EXEC;
          end else begin
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= ST_DONE;
          end
        end
        ST_EXEC: begin
          if (ph_last_s) begin
            rd_en_r   <= 1'b0;
            rd_addr_r <= {addr_bw{1'b0}};
            state_r   <= ST_DRAIN;
          end else begin
            rd_addr_r <= rd_addr_r + addr_bw'(1);
          end
        end
        ST_DRAIN: begin
          if (cap_last_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r    <= 1'b0;
          rd_en_r   <= 1'b0;
          rd_addr_r <= {addr_bw{1'b0}};
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.rd_en    = rd_en_r;
  assign bus.rd_addr  = rd_addr_r;
  assign bus.inst_w   = inst_r;
  assign bus.ofifo_wr = ofifo_r;

endmodule
